// File: rtl/receptor_pkg.sv
// Shared types and constants for the serial receiver.
// Optional parity support is selected with the RECEPTOR_PARIDADE_EN macro.
package receptor_pkg;

    // Default number of data bits per frame.
    localparam int unsigned LARGURA_PADRAO = 7;

    // Receiver FSM states; PARIDADE exists only when parity is built in.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
`ifdef RECEPTOR_PARIDADE_EN
        PARIDADE = 2'd2,
`endif
        DADOS    = 2'd1,
        PARADA   = 2'd3
    } estado_t;

endpackage

// File: rtl/contador_bits.sv
// Data-bit counter for the serial receiver: synchronous clear, count enable and a
// terminal flag raised while the counter sits on the last data bit.
module contador_bits #(
    parameter int unsigned LARGURA = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic limpar,
    input  logic habilitar,
    output logic terminal
);

    localparam int unsigned W = $clog2(LARGURA + 1);

    logic [W-1:0] cnt_q;

    // Count up on enable; saturate at LARGURA so the value never wraps mid-frame.
    always_ff @(posedge clk) begin
        if (reset || limpar) begin
            cnt_q <= '0;
        end else if (habilitar && (cnt_q != W'(LARGURA))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The strobe that sees this flag samples the final data bit.
    always_comb begin
        terminal = (cnt_q == W'(LARGURA - 1));
    end

endmodule

// File: rtl/receptor_serial7b.sv
// Strobed serial receiver: start bit, LARGURA data bits LSB first, optional even
// parity bit (RECEPTOR_PARIDADE_EN), stop bit. Line is sampled only when sinal=1.
module receptor_serial7b
    import receptor_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sinal,
    input  logic               entrada_serial,
    output logic [LARGURA-1:0] dados,
    output logic               valido,
    output logic               erro_quadro,
    output logic               ocupado
`ifdef RECEPTOR_PARIDADE_EN
    ,
    output logic               erro_paridade
`endif
);

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] shift_q, shift_d;
    logic [LARGURA-1:0] dados_q, dados_d;
    logic               valido_q, valido_d;
    logic               erro_quadro_q, erro_quadro_d;
    logic               cnt_limpar, cnt_hab, cnt_fim;
`ifdef RECEPTOR_PARIDADE_EN
    logic               par_pend_q, par_pend_d;
    logic               erro_par_q, erro_par_d;
`endif

    contador_bits #(
        .LARGURA (LARGURA)
    ) u_contador (
        .clk       (clk),
        .reset     (reset),
        .limpar    (cnt_limpar),
        .habilitar (cnt_hab),
        .terminal  (cnt_fim)
    );

    // State, shift register, output word and one-clock pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            shift_q       <= '0;
            dados_q       <= '0;
            valido_q      <= 1'b0;
            erro_quadro_q <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
            par_pend_q    <= 1'b0;
            erro_par_q    <= 1'b0;
`endif
        end else begin
            estado_q      <= estado_d;
            shift_q       <= shift_d;
            dados_q       <= dados_d;
            valido_q      <= valido_d;
            erro_quadro_q <= erro_quadro_d;
`ifdef RECEPTOR_PARIDADE_EN
            par_pend_q    <= par_pend_d;
            erro_par_q    <= erro_par_d;
`endif
        end
    end

    // Next-state logic; nothing advances unless the bit-time strobe is high.
    always_comb begin
        estado_d      = estado_q;
        shift_d       = shift_q;
        dados_d       = dados_q;
        valido_d      = 1'b0;
        erro_quadro_d = 1'b0;
        cnt_limpar    = 1'b0;
        cnt_hab       = 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
        par_pend_d    = par_pend_q;
        erro_par_d    = 1'b0;
`endif
        if (sinal) begin
            case (estado_q)
                OCIOSO: begin
                    if (!entrada_serial) begin
                        estado_d   = DADOS;
                        cnt_limpar = 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
                        par_pend_d = 1'b0;
`endif
                    end
                end
                DADOS: begin
                    // LSB arrives first, so shift right and enter at the MSB.
                    shift_d = {entrada_serial, shift_q[LARGURA-1:1]};
                    cnt_hab = 1'b1;
                    if (cnt_fim) begin
`ifdef RECEPTOR_PARIDADE_EN
                        estado_d = PARIDADE;
`else
                        estado_d = PARADA;
`endif
                    end
                end
`ifdef RECEPTOR_PARIDADE_EN
                PARIDADE: begin
                    // Even parity: data plus parity bit must XOR to zero.
                    par_pend_d = ^{shift_q, entrada_serial};
                    estado_d   = PARADA;
                end
`endif
                PARADA: begin
                    estado_d = OCIOSO;
                    if (entrada_serial) begin
`ifdef RECEPTOR_PARIDADE_EN
                        if (par_pend_q) begin
                            erro_par_d = 1'b1;
                        end else begin
                            dados_d  = shift_q;
                            valido_d = 1'b1;
                        end
`else
                        dados_d  = shift_q;
                        valido_d = 1'b1;
`endif
                    end else begin
                        erro_quadro_d = 1'b1;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    // Registered outputs; busy is simply "not idle".
    always_comb begin
        dados         = dados_q;
        valido        = valido_q;
        erro_quadro   = erro_quadro_q;
        ocupado       = (estado_q != OCIOSO);
`ifdef RECEPTOR_PARIDADE_EN
        erro_paridade = erro_par_q;
`endif
    end

endmodule

// File: tb/tb_receptor_serial7b.sv
// Self-checking bench for receptor_serial7b: directed frames followed by random
// frames, with a scoreboard of expected pulses consumed by a negedge monitor.
module tb_receptor_serial7b;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         sinal;
    logic         entrada_serial;
    logic [W-1:0] dados;
    logic         valido;
    logic         erro_quadro;
    logic         ocupado;
    logic         erro_par_w;

    receptor_serial7b dut (
        .clk            (clk),
        .reset          (reset),
        .sinal          (sinal),
        .entrada_serial (entrada_serial),
        .dados          (dados),
        .valido         (valido),
        .erro_quadro    (erro_quadro),
        .ocupado        (ocupado)
`ifdef RECEPTOR_PARIDADE_EN
        ,
        .erro_paridade  (erro_par_w)
`endif
    );

`ifndef RECEPTOR_PARIDADE_EN
    assign erro_par_w = 1'b0;
`endif

    always #5 clk = ~clk;

    // Expected event: kind 0 = valid word, 1 = framing error, 2 = parity error.
    typedef struct {
        int           kind;
        logic [W-1:0] word;
        int           cyc;
    } ev_t;

    ev_t          sb[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] dados_exp = '0;
    logic         exp_oc = 1'bx;
    bit           mon_en = 0;
    bit           fim = 0;
    bit           done = 0;
    int           gap_lo = 0;
    int           gap_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: consumes expected events as the DUT pulses and checks every sample.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL missing_pulse: no pulse at cycle %0d, wanted kind %0d word %h",
                         sb[0].cyc, sb[0].kind, sb[0].word);
                void'(sb.pop_front());
            end
            if (valido || erro_quadro || erro_par_w) begin
                int k;
                ev_t e;
                k = ($countones({valido, erro_quadro, erro_par_w}) > 1) ? 3 :
                    valido ? 0 : erro_quadro ? 1 : 2;
                total = total + 1;
                if (sb.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, wanted none", k, cyc);
                end else begin
                    e = sb.pop_front();
                    if (k != e.kind || cyc != e.cyc) begin
                        bad = bad + 1;
                        $display("FAIL pulse_kind_time: got kind %0d cycle %0d, wanted kind %0d cycle %0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                    if (e.kind == 0) dados_exp = e.word;
                end
                if (valido) begin
                    total = total + 1;
                    if (ocupado !== 1'b0) begin
                        bad = bad + 1;
                        $display("FAIL ocupado_at_valido: got %b, wanted 0", ocupado);
                    end
                end
            end
            total = total + 1;
            if (dados !== dados_exp) begin
                bad = bad + 1;
                $display("FAIL dados: got %h, wanted %h at cycle %0d", dados, dados_exp, cyc);
            end
            if (exp_oc !== 1'bx) begin
                total = total + 1;
                if (ocupado !== exp_oc) begin
                    bad = bad + 1;
                    $display("FAIL ocupado: got %b, wanted %b at cycle %0d", ocupado, exp_oc, cyc);
                end
            end
            if (fim && !done) begin
                total = total + 1;
                if (sb.size() != 0) begin
                    bad = bad + 1;
                    $display("FAIL leftover: got %0d pending events, wanted 0", sb.size());
                end
                done = 1;
            end
        end
    end

    // Reference: outcome of a frame from its start/data/parity/stop fields.
    function automatic int frame_kind(input logic [W-1:0] w, input bit par, input bit stop);
        if (!stop) return 1;
`ifdef RECEPTOR_PARIDADE_EN
        if (((^w) ^ par) != 1'b0) return 2;
`endif
        return 0;
    endfunction

    // One strobed bit: random non-strobe gap with junk on the line, then the strobe
    // edge. Optionally registers the expected pulse for this edge.
    task automatic strobe_bit(input bit b, input int kind, input logic [W-1:0] w);
        int g;
        ev_t e;
        g = (gap_hi > gap_lo) ? $urandom_range(gap_hi, gap_lo) : gap_lo;
        for (int i = 0; i < g; i++) begin
            sinal = 1'b0;
            entrada_serial = 1'($urandom);
            @(posedge clk);
            #1;
        end
        sinal = 1'b1;
        entrada_serial = b;
        if (kind >= 0) begin
            e.kind = kind;
            e.word = w;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        sinal = 1'b0;
        entrada_serial = 1'($urandom);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit stop, input bit par_ok);
        bit par;
        par = (^w) ^ !par_ok;
        strobe_bit(1'b0, -1, w);
        exp_oc = 1'b1;
        for (int i = 0; i < W; i++) strobe_bit(w[i], -1, w);
`ifdef RECEPTOR_PARIDADE_EN
        strobe_bit(par, -1, w);
`endif
        strobe_bit(stop, frame_kind(w, par, stop), w);
        exp_oc = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sinal = 1'b1;
        entrada_serial = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sinal = 1'b0;
        entrada_serial = 1'b1;
        dados_exp = '0;
        exp_oc = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sinal = 1'b0;
        entrada_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1;

        // Idle line, strobe every 4th clock.
        gap_lo = 3;
        gap_hi = 3;
        for (int i = 0; i < 25; i++) strobe_bit(1'b1, -1, '0);

        // Strobe every clock for the directed frames.
        gap_lo = 0;
        gap_hi = 0;
        send_frame(7'h55, 1'b1, 1'b1);
        send_frame(7'h2A, 1'b0, 1'b1);
        strobe_bit(1'b1, -1, '0);
        send_frame(7'h7F, 1'b1, 1'b1);
        send_frame(7'h01, 1'b1, 1'b1);

        // Abandon a frame after its third data bit.
        begin
            logic [W-1:0] w;
            w = 7'h33;
            strobe_bit(1'b0, -1, w);
            exp_oc = 1'b1;
            for (int i = 0; i < 3; i++) strobe_bit(w[i], -1, w);
            do_reset();
        end
        send_frame(7'h0C, 1'b1, 1'b1);

`ifdef RECEPTOR_PARIDADE_EN
        send_frame(7'h03, 1'b1, 1'b1);
        send_frame(7'h03, 1'b1, 1'b0);
`endif

        // Random frames with random strobe spacing and idle bits.
        for (int n = 0; n < 80; n++) begin
            logic [W-1:0] w;
            bit           stop;
            bit           pok;
            w      = W'($urandom);
            stop   = ($urandom_range(7, 0) != 0);
            pok    = ($urandom_range(5, 0) != 0);
            gap_lo = 0;
            gap_hi = $urandom_range(3, 0);
            send_frame(w, stop, pok);
            for (int j = $urandom_range(2, 0); j > 0; j--) strobe_bit(1'b1, -1, '0);
        end

        repeat (4) @(posedge clk);
        #1;
        fim = 1;
        while (!done) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, wanted completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/receptor_serial7b.md
RECEPTOR_SERIAL7B -- requirements
Module: receptor_serial7b

Interface
REQ-001 SHALL have parameter: LARGURA, 7, number of data bits per frame.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: sinal  input  1  bit-time strobe; line sampled only on clk edges where sinal=1.
REQ-005 SHALL have port: entrada_serial  input  1  serial line; idle high.
REQ-006 SHALL have port: dados  output  LARGURA  last valid received word.
REQ-007 SHALL have port: valido  output  1  one-clock pulse: new word in dados.
REQ-008 SHALL have port: erro_quadro  output  1  one-clock pulse: stop bit sampled low.
REQ-009 SHALL have port: ocupado  output  1  high while a frame is in progress (state not OCIOSO).

Function
REQ-010 SHALL accept frames: start bit 0, LARGURA data bits LSB first, [parity bit], stop bit 1.
REQ-011 SHALL implement FSM states OCIOSO, DADOS, PARIDADE, PARADA; transitions only on edges with sinal=1.
REQ-012 OCIOSO: sinal=1 and entrada_serial=0 -> DADOS, bit counter cleared; entrada_serial=1 -> stay.
REQ-013 DADOS: each strobe shifts entrada_serial into MSB of the internal shift register (shift right); after LARGURA strobes -> PARIDADE if PARIDADE_EN defined, else PARADA.
REQ-014 PARADA: on strobe with line=1, dados <= shift register and valido=1 for exactly the next clock, unless a parity error is pending; -> OCIOSO.
REQ-015 PARADA: on strobe with line=0, erro_quadro=1 for exactly one clock, dados unchanged, valido stays 0; -> OCIOSO.
REQ-016 Latency: valido/erro_* registered, asserted in the clock cycle immediately after the stop-bit sampling edge.
REQ-017 Edges with sinal=0 SHALL hold all state, counter, shift register and dados; pulses still clear after one clock.
REQ-018 A start bit SHALL be accepted on the first strobe after return to OCIOSO (back-to-back frames, no idle bit required beyond the stop bit).
REQ-019 Bit counter SHALL be ceil(log2(LARGURA+1)) bits and never wrap within a frame.
REQ-020 dados SHALL change only on a valid frame completion or reset.

Reset
REQ-021 reset=1 at a clk edge SHALL force state OCIOSO, counter 0, shift register 0, dados 0, valido 0, erro_quadro 0, erro_paridade 0, ocupado 0.
REQ-022 reset SHALL take priority over sinal; reset mid-frame abandons the frame with no valido or error pulse.

Configuration
REQ-023 Macro RECEPTOR_PARIDADE_EN defined: PARIDADE state present; one even-parity bit follows data; output port erro_paridade (1 bit) pulses one clock at frame end when XOR(data,parity)=1, suppressing valido and leaving dados unchanged.
REQ-024 Macro undefined: no PARIDADE state, no erro_paridade port, frame length LARGURA+2 strobes.

Structure
REQ-025 Package receptor_pkg SHALL hold the FSM state enum and the default LARGURA constant.
REQ-026 One sub-module contador_bits (clear, enable on strobe, terminal-count flag) SHALL be used; the shift register and FSM stay in receptor_serial7b.

Verification
REQ-027 Reset, then idle line with sinal every 4th clk for 100 clks -> ocupado=0, valido never asserted, dados=0.
REQ-028 Frame of word 7'h55 (no parity), sinal every clk -> valido one clock after stop sample, dados=7'h55, ocupado low same cycle.
REQ-029 Frame of 7'h2A with stop bit 0 -> erro_quadro one-clock pulse, valido=0, dados keeps previous 7'h55.
REQ-030 Two back-to-back frames 7'h7F then 7'h01 -> two valido pulses exactly LARGURA+2 strobes apart, dados 7'h7F then 7'h01.
REQ-031 reset asserted after 3rd data bit of 7'h33, then frame 7'h0C -> no pulse from first, dados=7'h0C after second.
REQ-032 With RECEPTOR_PARIDADE_EN: 7'h03 with parity 0 -> valido, dados=7'h03; with parity 1 -> erro_paridade pulse, valido=0.
